// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the shared multi-cycle multiply/divide unit:
// decodes R-type mul/div, issues one start pulse, stalls, and emits a writeback packet.
module multdiv_ctrl #(
  parameter int MAX_CYCLES   = 40,
  parameter int CNT_W        = 6,
  parameter int RSTATUS_REG  = 30,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_ins,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_lat;
  logic             op_div;

  logic [4:0] opcode, aluop;
  logic       is_mul, is_div, detect, timeout;
  logic       unused_ins;

  assign opcode     = in_ins[31:27];
  assign aluop      = in_ins[6:2];
  assign is_mul     = (opcode == 5'b00000) && (aluop == 5'b00110);
  assign is_div     = (opcode == 5'b00000) && (aluop == 5'b00111);
  assign detect     = in_valid && (is_mul || is_div) && !flush;
  assign timeout    = (cnt == CNT_W'(MAX_CYCLES - 1));
  assign unused_ins = ^{in_ins[21:7], in_ins[1:0]};

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        stall = detect;
        if (detect) state_next = START;
      end
      START: begin
        stall      = 1'b1;
        busy       = 1'b1;
        state_next = flush ? IDLE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush)                  state_next = IDLE;
        else if (md_ready || timeout) state_next = DONE;
      end
      // The instruction is still in execute during DONE, so detect is ignored.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_lat       <= '0;
      op_div       <= 1'b0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      md_opA       <= '0;
      md_opB       <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (detect) begin
            md_opA       <= in_opA;
            md_opB       <= in_opB;
            rd_lat       <= in_ins[26:22];
            op_div       <= is_div;
            md_ctrl_mult <= is_mul;
            md_ctrl_div  <= is_div;
          end
        end
        START: cnt <= '0;
        BUSY: begin
          cnt <= cnt + 1'b1;
          // md_ready takes precedence over a timeout landing in the same cycle.
          if (!flush) begin
            if (md_ready) begin
              wb_valid <= 1'b1;
              if (md_exception) begin
                wb_rd        <= 5'(RSTATUS_REG);
                wb_data      <= op_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
                wb_exception <= 1'b1;
              end else begin
                wb_rd   <= rd_lat;
                wb_data <= md_result;
              end
            end else if (timeout) begin
              wb_valid     <= 1'b1;
              wb_rd        <= 5'(RSTATUS_REG);
              wb_exception <= 1'b1;
              err_timeout  <= 1'b1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed testbench for multdiv_ctrl: each task drives one scenario and checks inline.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, flush, md_exception, md_ready;
  logic [31:0] in_ins, in_opA, in_opB, md_result;
  logic        md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_exception, err_timeout;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;
  int mult_pulses = 0;
  int div_pulses  = 0;
  int wb_count    = 0;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ins(in_ins),
    .in_opA(in_opA), .in_opB(in_opB), .flush(flush), .md_result(md_result),
    .md_exception(md_exception), .md_ready(md_ready), .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div(md_ctrl_div), .md_opA(md_opA), .md_opB(md_opB), .stall(stall),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (md_ctrl_mult === 1'b1) mult_pulses++;
    if (md_ctrl_div === 1'b1)  div_pulses++;
    if (wb_valid === 1'b1)     wb_count++;
  end

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                      input logic [4:0] aluop);
    return {opc, rd, 15'd0, aluop, 2'b00};
  endfunction

  function automatic logic [107:0] all_outs();
    return {md_ctrl_mult, md_ctrl_div, md_opA, md_opB, stall, busy, wb_valid,
            wb_rd, wb_data, wb_exception, err_timeout};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    @(negedge clock);
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_mul();
    int p_mul = mult_pulses;
    int p_div = div_pulses;
    @(negedge clock);
    in_valid = 1'b1; in_ins = mk(5'd0, 5'd3, 5'b00110);
    in_opA = 32'd7; in_opB = 32'd6; md_result = 32'd42;
    #1; total++;
    if ({stall, busy} !== 2'b10) begin
      bad++; $display("FAIL mul_detect_stall: got stall,busy=%b want 10", {stall, busy});
    end
    @(negedge clock); #1; total++;
    if ({md_ctrl_mult, md_ctrl_div, stall, md_opA, md_opB} !== {3'b101, 32'd7, 32'd6}) begin
      bad++; $display("FAIL mul_start: got m=%b d=%b st=%b A=%0d B=%0d want 1 0 1 7 6",
                      md_ctrl_mult, md_ctrl_div, stall, md_opA, md_opB);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 4) md_ready = 1'b1;
      #1; total++;
      if ({stall, busy, md_ctrl_mult, wb_valid} !== 4'b1100) begin
        bad++; $display("FAIL mul_busy_%0d: got st,bz,m,wb=%b want 1100", i,
                        {stall, busy, md_ctrl_mult, wb_valid});
      end
    end
    @(negedge clock);
    md_ready = 1'b0;
    #1; total++;
    if ({wb_valid, wb_rd, wb_data, wb_exception, stall, busy} !== {1'b1, 5'd3, 32'd42, 3'b000}) begin
      bad++; $display("FAIL mul_packet: got v=%b rd=%0d data=%0d exc=%b st=%b want 1 3 42 0 0",
                      wb_valid, wb_rd, wb_data, wb_exception, stall);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1; total++;
    if ({wb_valid, stall, busy} !== 3'b000) begin
      bad++; $display("FAIL mul_after_done: got v,st,bz=%b want 000", {wb_valid, stall, busy});
    end
    total++;
    if ((mult_pulses - p_mul) != 1 || (div_pulses - p_div) != 0) begin
      bad++; $display("FAIL mul_pulses: got mult=%0d div=%0d want 1 0",
                      mult_pulses - p_mul, div_pulses - p_div);
    end
    $display("mul 7*6 rd=3 -> data=%0d", wb_data);
  endtask

  task automatic test_div_zero();
    int p_mul = mult_pulses;
    int p_div = div_pulses;
    @(negedge clock);
    in_valid = 1'b1; in_ins = mk(5'd0, 5'd4, 5'b00111);
    in_opA = 32'd9; in_opB = 32'd0; md_result = 32'hDEAD_BEEF;
    @(negedge clock); #1; total++;
    if ({md_ctrl_div, md_ctrl_mult, md_opB} !== {2'b10, 32'd0}) begin
      bad++; $display("FAIL div_start: got d=%b m=%b B=%0d want 1 0 0",
                      md_ctrl_div, md_ctrl_mult, md_opB);
    end
    @(negedge clock);
    md_ready = 1'b1; md_exception = 1'b1;
    @(negedge clock);
    md_ready = 1'b0; md_exception = 1'b0;
    #1; total++;
    if ({wb_valid, wb_rd, wb_data, wb_exception} !== {1'b1, 5'd30, 32'd5, 1'b1}) begin
      bad++; $display("FAIL div_exc_packet: got v=%b rd=%0d data=%0d exc=%b want 1 30 5 1",
                      wb_valid, wb_rd, wb_data, wb_exception);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1; total++;
    if ((div_pulses - p_div) != 1 || (mult_pulses - p_mul) != 0) begin
      bad++; $display("FAIL div_pulses: got div=%0d mult=%0d want 1 0",
                      div_pulses - p_div, mult_pulses - p_mul);
    end
    $display("div 9/0 -> rd=30 code=5");
  endtask

  task automatic test_non_md();
    logic [31:0] ins_tab [2];
    int p_mul = mult_pulses;
    int p_div = div_pulses;
    int p_wb  = wb_count;
    ins_tab[0] = mk(5'b00101, 5'd3, 5'b00110);
    ins_tab[1] = mk(5'd0, 5'd3, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        in_valid = 1'b1; in_ins = ins_tab[k];
        #1; total++;
        if ({stall, busy} !== 2'b00) begin
          bad++; $display("FAIL non_md_stall_%0d_%0d: got st,bz=%b want 00", k, c, {stall, busy});
        end
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock); #1; total++;
    if ((mult_pulses - p_mul) + (div_pulses - p_div) + (wb_count - p_wb) != 0) begin
      bad++; $display("FAIL non_md_activity: got pulses=%0d packets=%0d want 0 0",
                      (mult_pulses - p_mul) + (div_pulses - p_div), wb_count - p_wb);
    end
    $display("non-md instructions ignored");
  endtask

  task automatic test_ready_at_limit();
    @(negedge clock);
    in_valid = 1'b1; in_ins = mk(5'd0, 5'd5, 5'b00110);
    in_opA = 32'd11; in_opB = 32'd7; md_result = 32'd77;
    @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 39) md_ready = 1'b1;
      #1;
      if (wb_valid !== 1'b0) begin
        total++; bad++; $display("FAIL limit_early_packet: got wb_valid=1 in busy %0d want 0", i);
      end
    end
    @(negedge clock);
    md_ready = 1'b0;
    #1; total++;
    if ({wb_valid, wb_rd, wb_data, wb_exception, err_timeout} !== {1'b1, 5'd5, 32'd77, 2'b00}) begin
      bad++; $display("FAIL ready_wins: got v=%b rd=%0d data=%0d exc=%b to=%b want 1 5 77 0 0",
                      wb_valid, wb_rd, wb_data, wb_exception, err_timeout);
    end
    @(negedge clock);
    in_valid = 1'b0;
    $display("ready on last busy cycle -> data=%0d", wb_data);
  endtask

  task automatic test_timeout();
    int n_busy = 0;
    bit seen   = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; in_ins = mk(5'd0, 5'd6, 5'b00110);
    in_opA = 32'd2; in_opB = 32'd2;
    @(negedge clock);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock); #1;
      if (wb_valid === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) n_busy++;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL timeout_no_packet: got none within 100 cycles want packet");
    end
    total++;
    if (n_busy != 40) begin
      bad++; $display("FAIL timeout_busy_cycles: got %0d want 40", n_busy);
    end
    total++;
    if ({wb_rd, wb_data, wb_exception, err_timeout} !== {5'd30, 32'd0, 2'b11}) begin
      bad++; $display("FAIL timeout_packet: got rd=%0d data=%0d exc=%b to=%b want 30 0 1 1",
                      wb_rd, wb_data, wb_exception, err_timeout);
    end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1; total++;
    if (err_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: got %b want 1", err_timeout);
    end
    $display("timeout after %0d busy cycles", n_busy);
  endtask

  task automatic test_flush();
    int p_mul = mult_pulses;
    int p_wb  = wb_count;
    @(negedge clock);
    in_valid = 1'b1; in_ins = mk(5'd0, 5'd7, 5'b00110);
    in_opA = 32'd5; in_opB = 32'd5;
    @(negedge clock);
    repeat (2) @(negedge clock);
    @(negedge clock);
    flush = 1'b1;
    #1; total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL flush_busy_stall: got %b want 1", stall);
    end
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    #1; total++;
    if ({stall, busy, wb_valid} !== 3'b000) begin
      bad++; $display("FAIL flush_idle: got st,bz,v=%b want 000", {stall, busy, wb_valid});
    end
    md_ready = 1'b1; md_result = 32'd99;
    @(negedge clock);
    md_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1; total++;
    if ((mult_pulses - p_mul) != 1 || (wb_count - p_wb) != 0) begin
      bad++; $display("FAIL flush_discard: got pulses=%0d packets=%0d want 1 0",
                      mult_pulses - p_mul, wb_count - p_wb);
    end
    $display("flush in busy cycle 3 -> no packet");
  endtask

  task automatic test_back_to_back();
    int p_mul;
    int p_wb;
    @(negedge clock);
    in_valid = 1'b1; in_ins = mk(5'd0, 5'd1, 5'b00110);
    in_opA = 32'd3; in_opB = 32'd5; md_result = 32'd15;
    @(negedge clock);
    @(negedge clock);
    md_ready = 1'b1;
    @(negedge clock);
    md_ready = 1'b0;
    in_ins = mk(5'd0, 5'd2, 5'b00110); in_opA = 32'd4; in_opB = 32'd4;
    #1; total++;
    if ({wb_valid, wb_rd, wb_data, wb_exception, stall} !== {1'b1, 5'd1, 32'd15, 2'b00}) begin
      bad++; $display("FAIL b2b_first_packet: got v=%b rd=%0d data=%0d exc=%b st=%b want 1 1 15 0 0",
                      wb_valid, wb_rd, wb_data, wb_exception, stall);
    end
    @(negedge clock); #1; total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL b2b_second_detect: got stall=%b want 1", stall);
    end
    @(negedge clock); #1; total++;
    if ({md_ctrl_mult, md_opA} !== {1'b1, 32'd4}) begin
      bad++; $display("FAIL b2b_second_start: got m=%b A=%0d want 1 4", md_ctrl_mult, md_opA);
    end
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    #1; total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL b2b_reset_outputs: got %h want 0", all_outs());
    end
    @(negedge clock);
    reset = 1'b0;
    p_mul = mult_pulses; p_wb = wb_count;
    md_ready = 1'b1; md_result = 32'd123;
    @(negedge clock);
    md_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1; total++;
    if ((mult_pulses - p_mul) != 0 || (wb_count - p_wb) != 0 || {stall, busy} !== 2'b00) begin
      bad++; $display("FAIL b2b_post_reset: got pulses=%0d packets=%0d st,bz=%b want 0 0 00",
                      mult_pulses - p_mul, wb_count - p_wb, {stall, busy});
    end
    $display("back-to-back mul then reset in busy");
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; md_exception = 1'b0; md_ready = 1'b0;
    in_ins = '0; in_opA = '0; in_opB = '0; md_result = '0;
    test_reset();
    test_mul();
    test_div_zero();
    test_non_md();
    test_ready_at_limit();
    test_timeout();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
